// File: rtl/mem_bus_responder.sv
// Memory-side responder: word-organised byte-lane RAM plus one output port register,
// serviced through a four-phase request/valid handshake.
module mem_bus_responder #(
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [31:0] IO_ADDR   = 32'h0000_2000,
  parameter              INIT_FILE = ""
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        rw_req,
  input  logic        rw,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  output logic [31:0] read_data,
  output logic        data_valid,
  output logic        port,
  output logic        fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        dv_q, dv_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        port_q, port_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_q;

  logic [1:0]  lane;
  logic [29:0] widx;
  logic        is_io, in_ram, misalign, bad;
  logic [3:0]  be;
  logic [31:0] wlanes, shifted, loaded;
  logic        access;

  // Decode of the latched request; everything below works only on latched values.
  assign lane     = addr_q[1:0];
  assign widx     = addr_q[31:2];
  assign is_io    = (widx == IO_ADDR[31:2]);
  assign in_ram   = ({2'b00, widx} < DEPTH);
  assign misalign = ((size_q == 2'd1) && lane[0]) || ((size_q == 2'd2) && (lane != 2'd0));
  assign bad      = (size_q == 2'd3) || misalign || (!in_ram && !is_io);

  always_comb begin
    be     = '0;
    wlanes = wdata_q;
    case (size_q)
      2'd0: begin
        be     = 4'b0001 << lane;
        wlanes = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be     = 4'b0011 << lane;
        wlanes = {2{wdata_q[15:0]}};
      end
      2'd2: be = 4'b1111;
      default: be = '0;
    endcase
  end

  assign shifted = ram_q >> {lane, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    loaded = {24'h0, shifted[7:0]};
      2'd1:    loaded = {16'h0, shifted[15:0]};
      default: loaded = shifted;
    endcase
  end

  // RAM is not reset; the access strobe is only raised from WAIT, so reset blocks it.
  always_ff @(posedge mclk) begin
    if (access) begin
      ram_q <= mem[widx[AW-1:0]];
      if (rw_q && !bad && !is_io) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[widx[AW-1:0]][8*i +: 8] <= wlanes[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
      dv_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      port_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      dv_q    <= dv_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      port_q  <= port_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    dv_d    = dv_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
    port_d  = port_q;
    access  = 1'b0;

    case (state_q)
      IDLE: begin
        dv_d = 1'b0;
        if (rw_req) begin
          addr_d  = address;
          rw_d    = rw;
          size_d  = size;
          wdata_d = write_data;
          cnt_d   = 4'(RD_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
          if (rw_q && is_io && !bad) port_d = wdata_q[0];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // First RESP cycle presents the result; later cycles only wait for release.
        if (!dv_q) begin
          dv_d    = 1'b1;
          fault_d = bad;
          if (bad || rw_q)  rdata_d = '0;
          else if (is_io)   rdata_d = {31'h0, port_q};
          else              rdata_d = loaded;
        end else if (!rw_req) begin
          dv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        dv_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign read_data  = rdata_q;
  assign data_valid = dv_q;
  assign port       = port_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomised bench for mem_bus_responder with a byte-addressed reference model
// and a per-cycle compare of data_valid, fault, port and read_data.
module tb_mem_bus_responder;

    localparam int unsigned LAT = 1;
    localparam logic [31:0] IOA = 32'h0000_2000;

    logic        mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic        reset, rw_req, rw, data_valid, port, fault;
    logic [31:0] address, write_data, read_data;
    logic [1:0]  size;

    logic        rst4, req4, rw4, dv4, port4, flt4;
    logic [31:0] addr4, wd4, rd4;
    logic [1:0]  sz4;

    mem_bus_responder #(.DEPTH(2048), .RD_LAT(LAT), .IO_ADDR(IOA)) u_dut (
        .mclk(mclk), .reset(reset), .address(address), .rw_req(rw_req), .rw(rw),
        .write_data(write_data), .size(size), .read_data(read_data),
        .data_valid(data_valid), .port(port), .fault(fault)
    );

    mem_bus_responder #(.DEPTH(2048), .RD_LAT(4), .IO_ADDR(IOA)) u_dut4 (
        .mclk(mclk), .reset(rst4), .address(addr4), .rw_req(req4), .rw(rw4),
        .write_data(wd4), .size(sz4), .read_data(rd4),
        .data_valid(dv4), .port(port4), .fault(flt4)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: memory as a flat byte array, handshake as an edge count.
    logic [7:0]  mb [8192];
    bit          m_busy = 0, m_dv = 0, m_flt = 0, m_port = 0, m_fpend = 0;
    int          m_lat = 0;
    logic [31:0] m_addr, m_wd, m_rd = '0;
    logic        m_rw;
    logic [1:0]  m_sz;

    function automatic void model_access();
        logic [29:0] widx;
        bit io, oob, mis, flt;
        int n;
        logic [12:0] bi;
        widx = m_addr[31:2];
        io   = (widx == IOA[31:2]);
        oob  = (widx >= 30'd2048) && !io;
        mis  = (m_sz == 2'd1 && m_addr[0]) || (m_sz == 2'd2 && m_addr[1:0] != 2'd0);
        flt  = (m_sz == 2'd3) || mis || oob;
        n    = (m_sz == 2'd0) ? 1 : (m_sz == 2'd1) ? 2 : 4;
        m_rd    = '0;
        m_fpend = flt;
        if (!flt) begin
            if (io) begin
                if (m_rw) m_port = m_wd[0];
                else      m_rd   = {31'h0, m_port};
            end else begin
                for (int i = 0; i < n; i++) begin
                    bi = m_addr[12:0] + 13'(i);
                    if (m_rw) mb[bi] = m_wd[8*i +: 8];
                    else      m_rd[8*i +: 8] = mb[bi];
                end
            end
        end
    endfunction

    always @(posedge mclk) begin
        bit          req_s, rw_s;
        logic [31:0] a_s, wd_s;
        logic [1:0]  sz_s;
        req_s = rw_req; rw_s = rw; a_s = address; wd_s = write_data; sz_s = size;
        if (reset) begin
            m_busy = 0; m_dv = 0; m_flt = 0; m_port = 0; m_rd = '0;
        end else begin
            m_flt = 0;
            if (m_dv) begin
                if (!req_s) m_dv = 0;
            end else if (m_busy) begin
                m_lat++;
                if (m_lat == 1 + LAT) model_access();
                if (m_lat == 2 + LAT) begin
                    m_dv = 1; m_busy = 0; m_flt = m_fpend;
                end
            end else if (req_s) begin
                m_busy = 1; m_lat = 0;
                m_addr = a_s; m_rw = rw_s; m_wd = wd_s; m_sz = sz_s;
            end
        end
        #1;
        if (!reset) begin
            chk("data_valid", {31'h0, data_valid}, {31'h0, m_dv});
            chk("fault", {31'h0, fault}, {31'h0, m_flt});
            chk("port", {31'h0, port}, {31'h0, m_port});
            if (m_dv && !m_rw) chk("read_data", read_data, m_rd);
        end
    end

    // Called on a negedge; returns on the negedge after rw_req has been dropped for one edge.
    task automatic xfer(input logic [31:0] a, input logic r, input logic [1:0] s,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic fl, output int lat);
        address = a; rw = r; size = s; write_data = d; rw_req = 1'b1; lat = 0;
        do begin
            @(negedge mclk); lat++;
        end while (!data_valid && lat < 40);
        if (!data_valid) begin
            checks++;
            $display("FAIL timeout: no data_valid for address %h", a);
        end
        rd = read_data; fl = fault;
        repeat (hold) begin
            @(negedge mclk);
            write_data = $urandom; address = $urandom; size = 2'($urandom); rw = 1'($urandom);
        end
        rw_req = 1'b0; address = $urandom; write_data = $urandom;
        @(negedge mclk);
    endtask

    task automatic acc4(input logic [31:0] a, input logic r, input logic [31:0] d,
                        output logic [31:0] rd);
        int n;
        addr4 = a; rw4 = r; sz4 = 2'd2; wd4 = d; req4 = 1'b1; n = 0;
        if (a == IOA) sz4 = 2'd0;
        do begin
            @(negedge mclk); n++;
        end while (!dv4 && n < 60);
        if (!dv4) begin
            checks++;
            $display("FAIL timeout4: no data_valid for address %h", a);
        end
        rd = rd4;
        req4 = 1'b0;
        @(negedge mclk);
    endtask

    initial begin
        logic [31:0] rd, d, a;
        logic        fl;
        int          lat, k, hold;
        logic [1:0]  s;
        logic        r;

        reset = 1'b1; rw_req = 1'b0; rw = 1'b0; address = '0; write_data = '0; size = '0;
        rst4 = 1'b1; req4 = 1'b0; rw4 = 1'b0; addr4 = '0; wd4 = '0; sz4 = '0;
        repeat (3) @(negedge mclk);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_data_valid", {31'h0, data_valid}, 32'h0);
        chk("rst_port", {31'h0, port}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        reset = 1'b0; rst4 = 1'b0;
        @(negedge mclk);

        xfer(32'h100, 1'b1, 2'd2, 32'hDEADBEEF, 0, rd, fl, lat);
        xfer(32'h100, 1'b0, 2'd2, 32'h0, 0, rd, fl, lat);
        chk("lw_100", rd, 32'hDEADBEEF);
        chk("lw_latency", 32'(lat), 32'd4);

        xfer(32'h200, 1'b1, 2'd2, 32'h11223344, 0, rd, fl, lat);
        xfer(32'h202, 1'b1, 2'd0, 32'h000000AA, 0, rd, fl, lat);
        xfer(32'h200, 1'b0, 2'd2, 32'h0, 0, rd, fl, lat);
        chk("lw_200", rd, 32'h11AA3344);
        xfer(32'h203, 1'b0, 2'd0, 32'h0, 0, rd, fl, lat);
        chk("lb_203", rd, 32'h00000011);
        xfer(32'h202, 1'b0, 2'd1, 32'h0, 0, rd, fl, lat);
        chk("lh_202", rd, 32'h000011AA);
        chk("lh_202_fault", {31'h0, fl}, 32'h0);
        xfer(32'h201, 1'b1, 2'd1, 32'h0000FFFF, 0, rd, fl, lat);
        chk("sh_201_fault", {31'h0, fl}, 32'h1);
        xfer(32'h200, 1'b0, 2'd2, 32'h0, 0, rd, fl, lat);
        chk("lw_200_after", rd, 32'h11AA3344);

        xfer(32'h300, 1'b1, 2'd2, 32'hA5A55A5A, 6, rd, fl, lat);
        xfer(32'h300, 1'b0, 2'd2, 32'h0, 0, rd, fl, lat);
        chk("lw_300_hold", rd, 32'hA5A55A5A);

        xfer(IOA, 1'b1, 2'd0, 32'h00000001, 0, rd, fl, lat);
        chk("io_port", {31'h0, port}, 32'h1);
        xfer(IOA, 1'b0, 2'd2, 32'h0, 0, rd, fl, lat);
        chk("io_read", rd, 32'h00000001);
        xfer(32'h4000, 1'b0, 2'd2, 32'h0, 0, rd, fl, lat);
        chk("oob_fault", {31'h0, fl}, 32'h1);
        chk("oob_data", rd, 32'h0);

        for (int w = 0; w < 64; w++)
            xfer(32'(w * 4), 1'b1, 2'd2, $urandom, 0, rd, fl, lat);

        for (int t = 0; t < 250; t++) begin
            k = $urandom_range(0, 99);
            s = 2'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 255));
            if (k < 70) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s == 2'd2) a[1:0] = 2'b00;
            end else if (k < 80) begin
                s = 2'($urandom_range(1, 2)); a[0] = 1'b1;
            end else if (k < 85) begin
                s = 2'd3;
            end else if (k < 92) begin
                s = 2'd0; a = IOA + 32'($urandom_range(0, 3));
            end else if (k < 96) begin
                s = 2'd2; a = 32'h4000 + 32'($urandom_range(0, 1023) * 4);
            end else begin
                s = 2'd2; a = $urandom | 32'h1000_0000; a[1:0] = 2'b00;
            end
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            hold = $urandom_range(0, 3);
            xfer(a, r, s, d, hold, rd, fl, lat);
        end

        acc4(32'h10, 1'b1, 32'hCAFE0001, rd);
        acc4(IOA, 1'b1, 32'h1, rd);
        chk("port4_set", {31'h0, port4}, 32'h1);
        addr4 = 32'h10; rw4 = 1'b1; sz4 = 2'd2; wd4 = 32'h5; req4 = 1'b1;
        @(posedge mclk);
        repeat (2) @(posedge mclk);
        #1 rst4 = 1'b1;
        #1;
        chk("rst4_dv", {31'h0, dv4}, 32'h0);
        chk("rst4_port", {31'h0, port4}, 32'h0);
        rw4 = 1'b0;
        repeat (2) @(negedge mclk);
        rst4 = 1'b0;
        k = 0;
        do begin
            @(negedge mclk); k++;
        end while (!dv4 && k < 60);
        if (!dv4) begin
            checks++;
            $display("FAIL timeout4: request held through reset not captured");
        end
        chk("lw4_old", rd4, 32'hCAFE0001);
        req4 = 1'b0;
        @(negedge mclk);
        chk("port4_after", {31'h0, port4}, 32'h0);
        chk("dv4_released", {31'h0, dv4}, 32'h0);

        repeat (2) @(negedge mclk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
